// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared memory-side widths and access size encoding
package params_pkg;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_LINE  = 3'd4
    } access_size_t;
endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - cache request/fill and memory port bundle of the request arbiter
interface mem_req_arbiter_if #(
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = 128
);
    import params_pkg::*;

    logic                  ic_req_valid_i;
    logic                  ic_req_ready_o;
    logic [ADDR_WIDTH-1:0] ic_req_addr_i;
    logic                  ic_fill_valid_o;
    logic [DATA_WIDTH-1:0] ic_fill_data_o;

    logic                  dc_req_valid_i;
    logic                  dc_req_ready_o;
    logic                  dc_req_is_wr_i;
    logic [ADDR_WIDTH-1:0] dc_req_addr_i;
    logic [DATA_WIDTH-1:0] dc_req_wdata_i;
    access_size_t          dc_req_size_i;
    logic                  dc_fill_valid_o;
    logic [DATA_WIDTH-1:0] dc_fill_data_o;

    logic                  mem_rd_req_valid_o;
    logic                  mem_wr_req_valid_o;
    logic                  mem_req_is_instr_o;
    logic [ADDR_WIDTH-1:0] mem_address_o;
    logic [DATA_WIDTH-1:0] mem_wr_data_o;
    access_size_t          mem_access_size_o;
    logic                  mem_data_valid_i;
    logic                  mem_data_is_instr_i;
    logic [DATA_WIDTH-1:0] mem_data_i;

    logic                  resp_err_o;

    modport slave (
        input  ic_req_valid_i, ic_req_addr_i,
        output ic_req_ready_o, ic_fill_valid_o, ic_fill_data_o,
        input  dc_req_valid_i, dc_req_is_wr_i, dc_req_addr_i, dc_req_wdata_i, dc_req_size_i,
        output dc_req_ready_o, dc_fill_valid_o, dc_fill_data_o,
        output mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
        output mem_address_o, mem_wr_data_o, mem_access_size_o,
        input  mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
        output resp_err_o
    );

    modport master (
        output ic_req_valid_i, ic_req_addr_i,
        input  ic_req_ready_o, ic_fill_valid_o, ic_fill_data_o,
        output dc_req_valid_i, dc_req_is_wr_i, dc_req_addr_i, dc_req_wdata_i, dc_req_size_i,
        input  dc_req_ready_o, dc_fill_valid_o, dc_fill_data_o,
        input  mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
        input  mem_address_o, mem_wr_data_o, mem_access_size_o,
        output mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
        input  resp_err_o
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin I/D-cache line request arbiter with tag-steered fills
// Optional MEM_ARB_STATS_EN adds stall/read counters and a response latency check.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH  = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = 128,
    parameter int MEM_LATENCY = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    mem_req_arbiter_if.slave       bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]            stat_ic_stall_o,
    output logic [31:0]            stat_dc_stall_o,
    output logic [31:0]            stat_rd_issued_o
`endif
);
    import params_pkg::*;

    typedef enum logic {SRC_IC, SRC_DC} src_e;

    src_e                  last_grant;
    logic                  ic_busy, dc_busy;
    logic                  ic_elig, dc_elig, ic_gnt, dc_gnt, ic_hit, dc_hit;
    logic                  rd_q, wr_q, instr_q, ic_fill_v_q, dc_fill_v_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, ic_fill_q, dc_fill_q;
    access_size_t          size_q;

    always_comb begin
        ic_elig = bus.ic_req_valid_i & ~ic_busy;
        dc_elig = bus.dc_req_valid_i & (bus.dc_req_is_wr_i | ~dc_busy);
        // On a tie the side that did not win last time goes first.
        ic_gnt  = ic_elig & (~dc_elig | (last_grant == SRC_DC));
        dc_gnt  = dc_elig & ~ic_gnt;
        ic_hit  = bus.mem_data_valid_i &  bus.mem_data_is_instr_i & ic_busy;
        dc_hit  = bus.mem_data_valid_i & ~bus.mem_data_is_instr_i & dc_busy;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= SRC_DC;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            instr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SIZE_BYTE;
        end else begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (ic_gnt) begin
                last_grant <= SRC_IC;
                rd_q       <= 1'b1;
                instr_q    <= 1'b1;
                addr_q     <= bus.ic_req_addr_i;
                size_q     <= SIZE_LINE;
            end else if (dc_gnt) begin
                last_grant <= SRC_DC;
                rd_q       <= ~bus.dc_req_is_wr_i;
                wr_q       <= bus.dc_req_is_wr_i;
                instr_q    <= 1'b0;
                addr_q     <= bus.dc_req_addr_i;
                wdata_q    <= bus.dc_req_wdata_i;
                size_q     <= bus.dc_req_size_i;
            end
        end
    end

    // A new grant and a matching response can coincide only if the flag was
    // already clear, so set takes priority over clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ic_busy     <= 1'b0;
            dc_busy     <= 1'b0;
            ic_fill_v_q <= 1'b0;
            dc_fill_v_q <= 1'b0;
            ic_fill_q   <= '0;
            dc_fill_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (ic_gnt)                             ic_busy <= 1'b1;
            else if (ic_hit)                        ic_busy <= 1'b0;
            if (dc_gnt && !bus.dc_req_is_wr_i)      dc_busy <= 1'b1;
            else if (dc_hit)                        dc_busy <= 1'b0;
            ic_fill_v_q <= ic_hit;
            dc_fill_v_q <= dc_hit;
            if (ic_hit) ic_fill_q <= bus.mem_data_i;
            if (dc_hit) dc_fill_q <= bus.mem_data_i;
            if (bus.mem_data_valid_i && !ic_hit && !dc_hit) err_q <= 1'b1;
        end
    end

    assign bus.ic_req_ready_o     = ic_gnt;
    assign bus.dc_req_ready_o     = dc_gnt;
    assign bus.ic_fill_valid_o    = ic_fill_v_q;
    assign bus.ic_fill_data_o     = ic_fill_q;
    assign bus.dc_fill_valid_o    = dc_fill_v_q;
    assign bus.dc_fill_data_o     = dc_fill_q;
    assign bus.mem_rd_req_valid_o = rd_q;
    assign bus.mem_wr_req_valid_o = wr_q;
    assign bus.mem_req_is_instr_o = instr_q;
    assign bus.mem_address_o      = addr_q;
    assign bus.mem_wr_data_o      = wdata_q;
    assign bus.mem_access_size_o  = size_q;
    assign bus.resp_err_o         = err_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0]            ic_stall_q, dc_stall_q, rd_cnt_q;
    logic [MEM_LATENCY-1:0] resp_due_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ic_stall_q <= '0;
            dc_stall_q <= '0;
            rd_cnt_q   <= '0;
            resp_due_q <= '0;
        end else begin
            if (bus.ic_req_valid_i && !ic_gnt && ic_stall_q != 32'hffff_ffff) ic_stall_q <= ic_stall_q + 32'd1;
            if (bus.dc_req_valid_i && !dc_gnt && dc_stall_q != 32'hffff_ffff) dc_stall_q <= dc_stall_q + 32'd1;
            if (rd_q && rd_cnt_q != 32'hffff_ffff)                             rd_cnt_q   <= rd_cnt_q + 32'd1;
            resp_due_q <= {resp_due_q[MEM_LATENCY-2:0], rd_q};
        end
    end

    // Responses must line up exactly MEM_LATENCY cycles behind each issued read.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (bus.mem_data_valid_i == resp_due_q[MEM_LATENCY-1]);
        end
    end

    assign stat_ic_stall_o  = ic_stall_q;
    assign stat_dc_stall_o  = dc_stall_q;
    assign stat_rd_issued_o = rd_cnt_q;
`else
    logic unused_latency;
    assign unused_latency = ^MEM_LATENCY;
`endif
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed and randomized bench for mem_req_arbiter with a transaction-level model
module tb_mem_req_arbiter;
    import params_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int LAT = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] st_ic, st_dc, st_rd;
`endif

    mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_ic_stall_o  (st_ic),
        .stat_dc_stall_o  (st_dc),
        .stat_rd_issued_o (st_rd)
`endif
    );

    // Reads in flight at the memory: due cycle, tag, data, and whether a reset
    // has since made the arbiter forget them.
    typedef struct {
        int            due;
        bit            instr;
        bit            orphan;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         rq[$];
    logic [DW-1:0] mem_img [logic [AW-1:0]];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;
    bit last_ic = 1'b0;

    logic          e_rd = 0, e_wr = 0, e_instr = 0, e_icf = 0, e_dcf = 0, e_err = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_icd = '0, e_dcd = '0;
    logic [2:0]    e_size = '0;

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {4{a ^ 32'h5a5a_0000}};
    endfunction

    function automatic bit busy(input bit instr);
        foreach (rq[i]) if (!rq[i].orphan && rq[i].instr == instr && rq[i].due >= cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic step(input bit r, input bit icv, input logic [AW-1:0] ica,
                        input bit dcv, input bit dcwr, input logic [AW-1:0] dca,
                        input logic [DW-1:0] dcwd, input logic [2:0] dcsz,
                        input bit inj, input bit inj_instr);
        int  hit;
        bit  icb, dcb, ic_el, dc_el, ic_w, dc_w;

        chk("mem_rd_valid", bus.mem_rd_req_valid_o, e_rd);
        chk("mem_wr_valid", bus.mem_wr_req_valid_o, e_wr);
        chk("mem_is_instr", bus.mem_req_is_instr_o, e_instr);
        chk("mem_addr", bus.mem_address_o, e_addr);
        chk("mem_size", bus.mem_access_size_o, e_size);
        if (e_wr) chk("mem_wdata", bus.mem_wr_data_o, e_wdata);
        chk("ic_fill_valid", bus.ic_fill_valid_o, e_icf);
        chk("dc_fill_valid", bus.dc_fill_valid_o, e_dcf);
        if (e_icf) chk("ic_fill_data", bus.ic_fill_data_o, e_icd);
        if (e_dcf) chk("dc_fill_data", bus.dc_fill_data_o, e_dcd);
        chk("resp_err", bus.resp_err_o, e_err);

        rst                 = r;
        bus.ic_req_valid_i  = icv;
        bus.ic_req_addr_i   = ica;
        bus.dc_req_valid_i  = dcv;
        bus.dc_req_is_wr_i  = dcwr;
        bus.dc_req_addr_i   = dca;
        bus.dc_req_wdata_i  = dcwd;
        bus.dc_req_size_i   = access_size_t'(dcsz);
        hit = -1;
        foreach (rq[i]) if (rq[i].due == cyc) hit = i;
        if (hit >= 0) begin
            bus.mem_data_valid_i    = 1'b1;
            bus.mem_data_is_instr_i = rq[hit].instr;
            bus.mem_data_i          = rq[hit].data;
        end else if (inj) begin
            bus.mem_data_valid_i    = 1'b1;
            bus.mem_data_is_instr_i = inj_instr;
            bus.mem_data_i          = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            bus.mem_data_valid_i    = 1'b0;
            bus.mem_data_is_instr_i = 1'b0;
            bus.mem_data_i          = '0;
        end
        #1;

        if (r) begin
            {e_rd, e_wr, e_instr, e_icf, e_dcf, e_err} = '0;
            e_addr = '0; e_wdata = '0; e_icd = '0; e_dcd = '0; e_size = '0;
            last_ic = 1'b0;
            foreach (rq[i]) rq[i].orphan = 1'b1;
        end else begin
            icb   = busy(1'b1);
            dcb   = busy(1'b0);
            ic_el = icv && !icb;
            dc_el = dcv && (dcwr || !dcb);
            ic_w  = ic_el && (!dc_el || !last_ic);
            dc_w  = dc_el && !ic_w;
            chk("ic_ready", bus.ic_req_ready_o, ic_w);
            chk("dc_ready", bus.dc_req_ready_o, dc_w);
            e_rd = 1'b0;
            e_wr = 1'b0;
            if (ic_w) begin
                e_rd = 1'b1; e_instr = 1'b1; e_addr = ica; e_size = SIZE_LINE; last_ic = 1'b1;
                rq.push_back('{due: cyc + 1 + LAT, instr: 1'b1, orphan: 1'b0, data: mem_read(ica)});
            end else if (dc_w) begin
                e_rd = !dcwr; e_wr = dcwr; e_instr = 1'b0; e_addr = dca; e_size = dcsz; last_ic = 1'b0;
                if (dcwr) begin
                    mem_img[dca] = dcwd;
                    e_wdata      = dcwd;
                end else begin
                    rq.push_back('{due: cyc + 1 + LAT, instr: 1'b0, orphan: 1'b0, data: mem_read(dca)});
                end
            end
            e_icf = 1'b0;
            e_dcf = 1'b0;
            if (hit >= 0) begin
                if (rq[hit].orphan)     e_err = 1'b1;
                else if (rq[hit].instr) begin e_icf = 1'b1; e_icd = rq[hit].data; end
                else                    begin e_dcf = 1'b1; e_dcd = rq[hit].data; end
            end else if (inj) begin
                e_err = 1'b1;
            end
        end
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due <= cyc) rq.delete(i);

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0, 0, 0, '0, '0, 3'd0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.ic_req_valid_i = 0; bus.ic_req_addr_i = '0;
        bus.dc_req_valid_i = 0; bus.dc_req_is_wr_i = 0; bus.dc_req_addr_i = '0;
        bus.dc_req_wdata_i = '0; bus.dc_req_size_i = SIZE_BYTE;
        bus.mem_data_valid_i = 0; bus.mem_data_is_instr_i = 0; bus.mem_data_i = '0;
        mem_img[32'h100] = {16{8'ha5}};
        @(posedge clk);
        @(negedge clk);

        // Lone I-cache fill of 0x100.
        t0 = cyc;
        step(0, 1, 32'h100, 0, 0, '0, '0, 3'd0, 0, 0);
        chk("t1_rd", bus.mem_rd_req_valid_o, 1'b1);
        chk("t1_addr", bus.mem_address_o, 32'h100);
        idle(11);
        chk("t1_fill_cycle", cyc - t0, 12);
        chk("t1_fill_valid", bus.ic_fill_valid_o, 1'b1);
        chk("t1_fill_data", bus.ic_fill_data_o, {16{8'ha5}});
        idle(2);

        // Both requesters from reset: I-cache first, D-cache next cycle.
        step(1, 0, '0, 0, 0, '0, '0, 3'd0, 0, 0);
        t0 = cyc;
        step(0, 1, 32'h200, 1, 0, 32'h300, '0, 3'd3, 0, 0);
        step(0, 1, 32'h200, 1, 0, 32'h300, '0, 3'd3, 0, 0);
        chk("t2_dc_addr", bus.mem_address_o, 32'h300);
        chk("t2_dc_instr", bus.mem_req_is_instr_o, 1'b0);
        idle(10);
        chk("t2_ic_fill", bus.ic_fill_valid_o, 1'b1);
        idle(1);
        chk("t2_dc_fill", bus.dc_fill_valid_o, 1'b1);
        chk("t2_dc_data", bus.dc_fill_data_o, {4{32'h5a5a_0300}});
        idle(2);

        // Writeback while a D-cache read is outstanding, then read it back.
        step(0, 0, '0, 1, 0, 32'h500, '0, 3'd2, 0, 0);
        step(0, 0, '0, 1, 1, 32'h400, 128'h1234, 3'd4, 0, 0);
        chk("t3_wr_valid", bus.mem_wr_req_valid_o, 1'b1);
        chk("t3_wr_data", bus.mem_wr_data_o, 128'h1234);
        idle(12);
        step(0, 0, '0, 1, 0, 32'h400, '0, 3'd4, 0, 0);
        idle(11);
        chk("t3_rb_data", bus.dc_fill_data_o, 128'h1234);
        idle(2);

        // Back-to-back I-cache requests must wait for the first fill.
        step(0, 1, 32'h600, 0, 0, '0, '0, 3'd0, 0, 0);
        repeat (14) step(0, 1, 32'h640, 0, 0, '0, '0, 3'd0, 0, 0);
        idle(13);

        // Spurious D-side response with nothing outstanding.
        chk("t5_err_before", bus.resp_err_o, 1'b0);
        step(0, 0, '0, 0, 0, '0, '0, 3'd0, 1, 0);
        idle(4);
        chk("t5_err_sticky", bus.resp_err_o, 1'b1);

        // Reset with both reads in flight; late responses become errors.
        step(1, 0, '0, 0, 0, '0, '0, 3'd0, 0, 0);
        step(0, 1, 32'h700, 1, 0, 32'h740, '0, 3'd1, 0, 0);
        step(0, 1, 32'h700, 1, 0, 32'h740, '0, 3'd1, 0, 0);
        idle(3);
        step(1, 0, '0, 0, 0, '0, '0, 3'd0, 0, 0);
        chk("t6_rst_rd", bus.mem_rd_req_valid_o, 1'b0);
        chk("t6_rst_err", bus.resp_err_o, 1'b0);
        idle(10);
        chk("t6_late_err", bus.resp_err_o, 1'b1);
        step(0, 1, 32'h780, 0, 0, '0, '0, 3'd0, 0, 0);
        idle(11);
        chk("t6_recover_fill", bus.ic_fill_valid_o, 1'b1);
        step(1, 0, '0, 0, 0, '0, '0, 3'd0, 0, 0);
        idle(1);

        // Randomized traffic over a small set of lines.
        repeat (600) begin
            step(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 6,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                 32'($urandom_range(0, 7)) << 6, {$urandom, $urandom, $urandom, $urandom},
                 3'($urandom_range(0, 4)), 0, 0);
        end
        idle(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
